fwd_scoreboard: RTL
===================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the 5-stage pipeline, the successor to the fixed two-source forwarding unit. It combines three functions:
- EX/MEM and MEM/WB operand-forwarding selects for NSRC source operands;
- load-use stall detection;
- a per-register countdown scoreboard that stalls ID while a variable-latency (multi-cycle) operation's result is outstanding.

It sits between the ID/EX and EX/MEM pipeline registers and drives the operand muxes and the PC/IF-ID write enables.

## Interface
- NREG, 32, architectural register count; register 0 is hard-wired zero
- RW, $clog2(NREG), register index width
- NSRC, 2, source operands per instruction
- MAX_LAT, 7, maximum multi-cycle latency; counter width CW = $clog2(MAX_LAT+1)
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- IFID_Valid_i  in  1  ID-stage instruction is valid (0 on bubble or flush)
- IFID_Src_i  in  NSRC*RW  ID-stage source indices; source k is at [k*RW +: RW]
- IFID_RegRd_i  in  RW  ID-stage destination
- IFID_RegWr_i  in  1  ID-stage instruction writes a register
- IFID_Long_i  in  1  ID-stage instruction is multi-cycle
- IFID_Lat_i  in  CW  latency of that multi-cycle instruction
- IDEX_Src_i  in  NSRC*RW  EX-stage source indices
- IDEX_RegRd_i  in  RW  EX-stage destination
- IDEX_MemRd_i  in  1  EX-stage instruction is a load
- EXMEM_RegRd_i  in  RW  EX/MEM destination
- EXMEM_RegWr_i  in  1  EX/MEM write enable
- MEMWB_RegRd_i  in  RW  MEM/WB destination
- MEMWB_RegWr_i  in  1  MEM/WB write enable
- Fw_o  out  2*NSRC  forwarding select per EX source, at [2k +: 2]
- Stall_o  out  1  hold PC and IF/ID, inject bubble into ID/EX
- Busy_o  out  NREG  per-register scoreboard busy flags
- StallCnt_o  out  16  saturating count of stall cycles

## Operation
- **Forwarding** (combinational) for each source k, with s = IDEX_Src_i[k]:
  - FW_EX (2'b10) if EXMEM_RegWr_i, EXMEM_RegRd_i != 0 and s == EXMEM_RegRd_i;
  - else FW_WB (2'b01) if MEMWB_RegWr_i, MEMWB_RegRd_i != 0 and s == MEMWB_RegRd_i;
  - else FW_RF (2'b00). 2'b11 is never driven.
  - Register 0 is never forwarded from either stage.
- **Load-use:** asserted when IDEX_MemRd_i, IDEX_RegRd_i != 0 and any IFID source equals IDEX_RegRd_i.
- **Scoreboard:** one CW-bit counter cnt[r] per register r = 1..NREG-1; cnt[0] is constant 0. Busy_o[r] = (cnt[r] != 0).
- **Scoreboard hazard:** any IFID source r != 0 with Busy_o[r] (RAW), or IFID_RegWr_i with Busy_o[IFID_RegRd_i] (WAW).
- **Stall_o** = IFID_Valid_i & (load-use | scoreboard hazard). When IFID_Valid_i = 0, Stall_o = 0 regardless of the other inputs.
- **Issue:** happens at a clock edge when all of the following hold: IFID_Valid_i, IFID_Long_i, IFID_RegWr_i, IFID_RegRd_i != 0, IFID_Lat_i != 0 and !Stall_o. On issue, cnt[IFID_RegRd_i] <= IFID_Lat_i.
  - IFID_Lat_i = 0 is treated as a single-cycle op: no issue.
  - IFID_Lat_i > MAX_LAT saturates to MAX_LAT.
- **Decrement:** every non-issued counter that is nonzero decrements by 1 each clock.
- **Simultaneous issue and decrement on the same register:** impossible, because the WAW check stalls while cnt != 0. Issue takes priority if the WAW check is violated by misuse.
- **StallCnt_o** increments on every clock edge with Stall_o = 1 and holds at 16'hFFFF.
- **Reset** (rst_i low, any time, including mid-countdown): all cnt = 0, StallCnt_o = 0. Outputs settle combinationally to Busy_o = 0, and Stall_o and Fw_o are determined by the current inputs only.

## Timing
- Fw_o and Stall_o are combinational from inputs and current counter state, with zero latency.
- Issue at edge t with latency L:
  - Busy_o[rd] = 1 from after edge t through edge t+L-1, then 0 after edge t+L.
  - A dependent instruction in ID stalls for exactly L cycles when it immediately follows the issuing instruction.
- Load-use stall lasts one cycle: on the next cycle the load has moved to MEM, and the dependency resolves through FW_WB in the following cycle.
- Busy_o and StallCnt_o are registered and change only on clk_i rising edges or on assertion of reset.

## Structure
- Package fwd_pkg holds:
  - localparams FW_RF = 2'b00, FW_WB = 2'b01, FW_EX = 2'b10;
  - typedef fw_sel_t (2-bit);
  - the helper function sat_lat().
- Sub-module fwd_sb_entry: one per register r >= 1, generated NREG-1 times. It contains one CW-bit counter with ports clk_i, rst_i, load, load_val, busy. The top level holds the forwarding compare, hazard OR-reduction and stall counter.

## Test plan
- **Forwarding priority:** EXMEM_RegRd = MEMWB_RegRd = 5, both with Wr = 1, and IDEX_Src0 = 5 -> Fw_o[1:0] = 2'b10. With EXMEM_RegWr = 0 -> 2'b01. With all indices 0 -> 2'b00.
- **Load-use:** IDEX_MemRd = 1, IDEX_RegRd = 8, IFID_Src1 = 8, valid -> Stall_o = 1 for one cycle and StallCnt_o = 1. With IFID_Valid = 0 -> Stall_o = 0.
- **Scoreboard RAW:** issue Long, Rd = 3, Lat = 4 -> Busy_o[3] high for exactly 4 cycles. A following instruction reading r3 sees Stall_o = 1 for 4 cycles, then Stall_o = 0 and Fw_o = 2'b00.
- **WAW and Lat clamp:** issue Rd = 9 with Lat = 15 on MAX_LAT = 7 -> busy for 7 cycles. A second Long op writing r9 stalls until Busy_o[9] = 0, then issues.
- **Reset mid-countdown:** issue Rd = 4, Lat = 6, then assert rst_i low after 2 cycles -> Busy_o = 0 immediately, StallCnt_o = 0, and there is no residual stall after release.
- **Saturation:** hold the stall condition for 70000 cycles -> StallCnt_o = 16'hFFFF with no wrap.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared types, forwarding select encodings and the latency clamp helper
// for the forwarding / hazard scoreboard.
package fwd_pkg;

  typedef logic [1:0] fw_sel_t;

  localparam fw_sel_t FW_RF = 2'b00;  // operand comes from the register file
  localparam fw_sel_t FW_WB = 2'b01;  // operand comes from the MEM/WB result
  localparam fw_sel_t FW_EX = 2'b10;  // operand comes from the EX/MEM result

  // Clamp a requested multi-cycle latency to the deepest the counters allow.
  function automatic logic [31:0] sat_lat(input logic [31:0] lat,
                                          input logic [31:0] max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Bundle of pipeline-side signals seen by the forwarding scoreboard.
// There is no valid/ready handshake here: IFID_Valid_i qualifies the ID-stage
// fields only; every other field is a level sampled each cycle, and the
// scoreboard never back-pressures except through Stall_o.
interface fwd_scoreboard_if #(
  parameter int NREG    = 32,
  parameter int NSRC    = 2,
  parameter int MAX_LAT = 7
);
  import fwd_pkg::*;

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(MAX_LAT + 1);

  logic                 IFID_Valid_i;
  logic [NSRC*RW-1:0]   IFID_Src_i;
  logic [RW-1:0]        IFID_RegRd_i;
  logic                 IFID_RegWr_i;
  logic                 IFID_Long_i;
  logic [CW-1:0]        IFID_Lat_i;
  logic [NSRC*RW-1:0]   IDEX_Src_i;
  logic [RW-1:0]        IDEX_RegRd_i;
  logic                 IDEX_MemRd_i;
  logic [RW-1:0]        EXMEM_RegRd_i;
  logic                 EXMEM_RegWr_i;
  logic [RW-1:0]        MEMWB_RegRd_i;
  logic                 MEMWB_RegWr_i;
  logic [2*NSRC-1:0]    Fw_o;
  logic                 Stall_o;
  logic [NREG-1:0]      Busy_o;
  logic [15:0]          StallCnt_o;

  // Pipeline side: drives stage fields, consumes selects and stall.
  modport master (
    output IFID_Valid_i, IFID_Src_i, IFID_RegRd_i, IFID_RegWr_i, IFID_Long_i,
           IFID_Lat_i, IDEX_Src_i, IDEX_RegRd_i, IDEX_MemRd_i, EXMEM_RegRd_i,
           EXMEM_RegWr_i, MEMWB_RegRd_i, MEMWB_RegWr_i,
    input  Fw_o, Stall_o, Busy_o, StallCnt_o
  );

  // Scoreboard side.
  modport slave (
    input  IFID_Valid_i, IFID_Src_i, IFID_RegRd_i, IFID_RegWr_i, IFID_Long_i,
           IFID_Lat_i, IDEX_Src_i, IDEX_RegRd_i, IDEX_MemRd_i, EXMEM_RegRd_i,
           EXMEM_RegWr_i, MEMWB_RegRd_i, MEMWB_RegWr_i,
    output Fw_o, Stall_o, Busy_o, StallCnt_o
  );

endinterface

// File: rtl/fwd_scoreboard_sb_entry.sv
// One scoreboard slot: a countdown of cycles until a multi-cycle result for
// this register is written back. Busy while the count is nonzero.
module fwd_sb_entry
  import fwd_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a new issue overrides any countdown in progress.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding selects, load-use detection and a per-register
// countdown scoreboard for multi-cycle ops, producing the ID-stage stall.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int NSRC    = 2,
  parameter int MAX_LAT = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fwd_scoreboard_if.slave  bus
);

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(MAX_LAT + 1);

  logic [NREG-1:0]   busy;
  logic [2*NSRC-1:0] fw;
  logic              load_use;
  logic              raw_haz;
  logic              waw_haz;
  logic              stall;
  logic              issue;
  logic [CW-1:0]     lat_sat;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  // Forwarding select per EX source; EX/MEM wins over MEM/WB, r0 never forwards.
  always_comb begin
    fw = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.EXMEM_RegWr_i && (bus.EXMEM_RegRd_i != '0) &&
          (bus.IDEX_Src_i[k*RW +: RW] == bus.EXMEM_RegRd_i)) begin
        fw[2*k +: 2] = FW_EX;
      end else if (bus.MEMWB_RegWr_i && (bus.MEMWB_RegRd_i != '0) &&
                   (bus.IDEX_Src_i[k*RW +: RW] == bus.MEMWB_RegRd_i)) begin
        fw[2*k +: 2] = FW_WB;
      end else begin
        fw[2*k +: 2] = FW_RF;
      end
    end
  end

  // Hazard detection for the instruction sitting in ID.
  always_comb begin
    load_use = 1'b0;
    raw_haz  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.IDEX_MemRd_i && (bus.IDEX_RegRd_i != '0) &&
          (bus.IFID_Src_i[k*RW +: RW] == bus.IDEX_RegRd_i)) begin
        load_use = 1'b1;
      end
      if ((bus.IFID_Src_i[k*RW +: RW] != '0) && busy[bus.IFID_Src_i[k*RW +: RW]]) begin
        raw_haz = 1'b1;
      end
    end
    waw_haz = bus.IFID_RegWr_i && busy[bus.IFID_RegRd_i];
    stall   = bus.IFID_Valid_i && (load_use || raw_haz || waw_haz);
  end

  // A multi-cycle op claims its destination only when it actually leaves ID.
  assign issue = bus.IFID_Valid_i && bus.IFID_Long_i && bus.IFID_RegWr_i &&
                 (bus.IFID_RegRd_i != '0) && (bus.IFID_Lat_i != '0) && !stall;

  assign lat_sat = CW'(sat_lat(32'(bus.IFID_Lat_i), 32'(MAX_LAT)));

  // Register 0 is hard-wired zero and can never be outstanding.
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    fwd_sb_entry #(.CW(CW)) u_entry (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (issue && (bus.IFID_RegRd_i == RW'(r))),
      .load_val (lat_sat),
      .busy     (busy[r])
    );
  end

  // Stall-cycle count, saturating rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.Fw_o       = fw;
  assign bus.Stall_o    = stall;
  assign bus.Busy_o     = busy;
  assign bus.StallCnt_o = stall_cnt_q;

endmodule
